hollywood_hash_search: RTL

// Parametrised successor of the single-stream password hash checker. Consumes

---
 rtl/hollywood_hash_search.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/hollywood_hash_search.sv
// Framed password-candidate hash checker: runs the r4/r6 hash over each
// sop..eop candidate and reports one result per candidate.
module hollywood_hash_search #(
    parameter int unsigned      DATA_W    = 16,
    parameter int unsigned      IDX_W     = 32,
    parameter logic [DATA_W-1:0] R4_TARGET = DATA_W'(16'hFEB1),
    parameter logic [DATA_W-1:0] R6_TARGET = DATA_W'(16'h9298),
    parameter logic [DATA_W-1:0] INIT_R4   = '0,
    parameter logic [DATA_W-1:0] INIT_R6   = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_match,
    output logic [IDX_W-1:0]  out_index,
    output logic [DATA_W-1:0] out_r4,
    output logic [DATA_W-1:0] out_r6,
    output logic [IDX_W-1:0]  match_count,
    output logic              proto_err
);

    localparam int unsigned HALF = DATA_W / 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        CHECK  = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   r4_q, r4_d;
    logic [DATA_W-1:0]   r6_q, r6_d;
    logic                out_valid_q, out_valid_d;
    logic                out_match_q, out_match_d;
    logic [IDX_W-1:0]    out_index_q, out_index_d;
    logic [DATA_W-1:0]   out_r4_q, out_r4_d;
    logic [DATA_W-1:0]   out_r6_q, out_r6_d;
    logic [IDX_W-1:0]    match_count_q, match_count_d;
    logic                proto_err_q, proto_err_d;

    logic                beat;
    logic [DATA_W-1:0]   sw, base_r4, base_r6, sum, hash_r4, hash_r6;

    function automatic logic [DATA_W-1:0] half_swap(input logic [DATA_W-1:0] x);
        return {x[HALF-1:0], x[DATA_W-1:HALF]};
    endfunction

    // Ready depends only on state so the generator never sees a valid->ready loop.
    assign in_ready = (state_q == IDLE) || (state_q == ACCUM);
    assign beat     = in_valid && in_ready;

    // One hash round; an sop beat restarts from the initial values.
    always_comb begin
        sw      = half_swap(in_data);
        base_r4 = in_sop ? INIT_R4 : r4_q;
        base_r6 = in_sop ? INIT_R6 : r6_q;
        hash_r4 = base_r6 ^ sw;
        sum     = base_r4 + sw;
        hash_r6 = half_swap(sum);
    end

    always_comb begin
        state_d       = state_q;
        r4_d          = r4_q;
        r6_d          = r6_q;
        out_valid_d   = out_valid_q;
        out_match_d   = out_match_q;
        out_index_d   = out_index_q;
        out_r4_d      = out_r4_q;
        out_r6_d      = out_r6_q;
        match_count_d = match_count_q;
        proto_err_d   = proto_err_q;

        case (state_q)
            IDLE: begin
                if (beat) begin
                    if (in_sop) begin
                        r4_d    = hash_r4;
                        r6_d    = hash_r6;
                        state_d = in_eop ? CHECK : ACCUM;
                    end else begin
                        proto_err_d = 1'b1;
                    end
                end
            end
            ACCUM: begin
                if (beat) begin
                    if (in_sop) begin
                        proto_err_d = 1'b1;
                    end
                    r4_d    = hash_r4;
                    r6_d    = hash_r6;
                    state_d = in_eop ? CHECK : ACCUM;
                end
            end
            CHECK: begin
                out_match_d = (r4_q == R4_TARGET) && (r6_q == R6_TARGET);
                out_r4_d    = r4_q;
                out_r6_d    = r6_q;
                out_valid_d = 1'b1;
                state_d     = REPORT;
            end
            REPORT: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    out_index_d = out_index_q + IDX_W'(1);
                    if (out_match_q && (match_count_q != '1)) begin
                        match_count_d = match_count_q + IDX_W'(1);
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            r4_q          <= INIT_R4;
            r6_q          <= INIT_R6;
            out_valid_q   <= 1'b0;
            out_match_q   <= 1'b0;
            out_index_q   <= '0;
            out_r4_q      <= '0;
            out_r6_q      <= '0;
            match_count_q <= '0;
            proto_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            r4_q          <= r4_d;
            r6_q          <= r6_d;
            out_valid_q   <= out_valid_d;
            out_match_q   <= out_match_d;
            out_index_q   <= out_index_d;
            out_r4_q      <= out_r4_d;
            out_r6_q      <= out_r6_d;
            match_count_q <= match_count_d;
            proto_err_q   <= proto_err_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_match   = out_match_q;
    assign out_index   = out_index_q;
    assign out_r4      = out_r4_q;
    assign out_r6      = out_r6_q;
    assign match_count = match_count_q;
    assign proto_err   = proto_err_q;

endmodule
